// File: rtl/switch_mcu_pkg.sv
// Shared definitions for the switch MCU core: request encodings, merge modes,
// flush-controller state and the default instruction-boundary phase.
package switch_mcu_pkg;

    typedef enum int unsigned {
        FLUSH_DISABLE = 0,
        FLUSH_CYCLE1  = 1,
        FLUSH_CYCLE2  = 2
    } flush_req_e;

    typedef enum int unsigned {
        MERGE_MAX = 0,
        MERGE_ACC = 1
    } merge_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

    localparam int unsigned DEF_TRIG_CNT = 4;

endpackage

// File: rtl/switch_mcu_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module switch_mcu_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         in_clk,
    input  logic         in_rst,
    input  logic         in_inc,
    input  logic         in_clr,
    output logic [W-1:0] out_cnt
);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_cnt <= '0;
        end else if (in_clr) begin
            out_cnt <= '0;
        end else if (in_inc && (out_cnt != '1)) begin
            out_cnt <= out_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/switch_mcu_ex_flush_ctrl.sv
// EX-stage flush/stall controller: samples flush requests at instruction
// boundaries, counts remaining flush periods and tracks stalled cycles.
module switch_mcu_ex_flush_ctrl
    import switch_mcu_pkg::*;
#(
    parameter  int unsigned CNT_W      = 4,
    parameter  int unsigned FLUSH_W    = 2,
    parameter  int unsigned TRIG_CNT   = DEF_TRIG_CNT,
    parameter  int unsigned MAX_FLUSH  = 3,
    parameter  int unsigned MERGE_MODE = MERGE_MAX,
    parameter  int unsigned PERF_W     = 16,
    localparam int unsigned REM_W      = $clog2(MAX_FLUSH + 1)
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic [CNT_W-1:0]   in_cycle_cnt,
    input  logic [FLUSH_W-1:0] in_flush,
    input  logic               in_abort,
    input  logic               in_perf_clr,
    output logic               out_stall,
    output logic [REM_W-1:0]   out_flush_remain,
    output logic               out_flush_done,
    output logic               out_sat,
    output logic [PERF_W-1:0]  out_perf_cnt
);

    // Arithmetic width holds any request, MAX_FLUSH and the MODE-1 sum.
    localparam int unsigned AW = ((FLUSH_W > REM_W) ? FLUSH_W : REM_W) + 1;

    if (TRIG_CNT >= (2 ** CNT_W)) begin : g_bad_trig
        $error("TRIG_CNT must be < 2**CNT_W");
    end
    if (MAX_FLUSH < 1) begin : g_bad_max
        $error("MAX_FLUSH must be >= 1");
    end

    flush_state_e     state_q, state_d;
    logic [REM_W-1:0] remain_q, remain_d;
    logic             done_q, done_d;
    logic             sat_q, sat_d;

    logic             boundary;
    logic [AW-1:0]    flush_w, max_w, req_w, base_w, sum_w, merged_w;
    logic             req_clip, sum_clip;

    assign boundary = (in_cycle_cnt == CNT_W'(TRIG_CNT));
    assign flush_w  = AW'(in_flush);
    assign max_w    = AW'(MAX_FLUSH);
    assign req_clip = (flush_w > max_w);
    assign req_w    = req_clip ? max_w : flush_w;
    assign base_w   = AW'(remain_q) - AW'(1);
    assign sum_w    = base_w + req_w;

    always_comb begin
        merged_w = '0;
        sum_clip = 1'b0;
        if (MERGE_MODE == MERGE_ACC) begin
            sum_clip = (sum_w > max_w);
            merged_w = sum_clip ? max_w : sum_w;
        end else begin
            merged_w = (base_w > req_w) ? base_w : req_w;
        end
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        sat_d    = 1'b0;
        if (in_abort) begin
            remain_d = '0;
            state_d  = ST_IDLE;
        end else if (boundary) begin
            if (remain_q == '0) begin
                remain_d = REM_W'(req_w);
                sat_d    = req_clip;
            end else begin
                remain_d = REM_W'(merged_w);
                sat_d    = req_clip | sum_clip;
                done_d   = (merged_w == '0);
            end
            state_d = (remain_d != '0) ? ST_FLUSH : ST_IDLE;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            done_q   <= done_d;
            sat_q    <= sat_d;
        end
    end

    assign out_stall        = (state_q == ST_FLUSH);
    assign out_flush_remain = remain_q;
    assign out_flush_done   = done_q;
    assign out_sat          = sat_q;

    switch_mcu_sat_cnt #(
        .W(PERF_W)
    ) u_perf_cnt (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .in_inc (out_stall),
        .in_clr (in_perf_clr),
        .out_cnt(out_perf_cnt)
    );

endmodule

// File: tb/tb_switch_mcu_ex_flush_ctrl.sv
// Directed-vector bench: a default-parameter instance (MODE 0) and a MODE 1
// instance with a 3-bit request and 4-bit perf counter, checked against hand values.
module tb_switch_mcu_ex_flush_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cnt = '0;
    logic       abort = 1'b0;
    logic       perf_clr = 1'b0;

    logic [1:0]  flush0 = '0;
    logic        stall0, done0, sat0;
    logic [1:0]  remain0;
    logic [15:0] perf0;

    logic [2:0] flush1 = '0;
    logic       stall1, done1, sat1;
    logic [1:0] remain1;
    logic [3:0] perf1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    switch_mcu_ex_flush_ctrl u_dut0 (
        .in_clk          (clk),
        .in_rst          (rst),
        .in_cycle_cnt    (cnt),
        .in_flush        (flush0),
        .in_abort        (abort),
        .in_perf_clr     (perf_clr),
        .out_stall       (stall0),
        .out_flush_remain(remain0),
        .out_flush_done  (done0),
        .out_sat         (sat0),
        .out_perf_cnt    (perf0)
    );

    switch_mcu_ex_flush_ctrl #(
        .FLUSH_W   (3),
        .MERGE_MODE(1),
        .PERF_W    (4)
    ) u_dut1 (
        .in_clk          (clk),
        .in_rst          (rst),
        .in_cycle_cnt    (cnt),
        .in_flush        (flush1),
        .in_abort        (abort),
        .in_perf_clr     (perf_clr),
        .out_stall       (stall1),
        .out_flush_remain(remain1),
        .out_flush_done  (done1),
        .out_sat         (sat1),
        .out_perf_cnt    (perf1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [1:0] rem, input logic st,
                        input logic dn, input logic sa);
        chk({tag, ".remain0"}, 32'(remain0), 32'(rem));
        chk({tag, ".stall0"},  32'(stall0),  32'(st));
        chk({tag, ".done0"},   32'(done0),   32'(dn));
        chk({tag, ".sat0"},    32'(sat0),    32'(sa));
    endtask

    task automatic chk1(input string tag, input logic [1:0] rem, input logic st,
                        input logic dn, input logic sa);
        chk({tag, ".remain1"}, 32'(remain1), 32'(rem));
        chk({tag, ".stall1"},  32'(stall1),  32'(st));
        chk({tag, ".done1"},   32'(done1),   32'(dn));
        chk({tag, ".sat1"},    32'(sat1),    32'(sa));
    endtask

    initial begin
        // Reset state
        #2;
        chk0("rst", 2'd0, 1'b0, 1'b0, 1'b0);
        chk1("rst", 2'd0, 1'b0, 1'b0, 1'b0);
        chk("rst.perf0", 32'(perf0), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: flush=2 at the boundary, countdown 2,1,0 with one done pulse
        cnt = 4'd4; flush0 = 2'd2; tick();
        chk0("t1.load", 2'd2, 1'b1, 1'b0, 1'b0);
        cnt = 4'd0; flush0 = 2'd0; tick();
        chk0("t1.hold", 2'd2, 1'b1, 1'b0, 1'b0);
        cnt = 4'd4; tick();
        chk0("t1.b1", 2'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk0("t1.b2", 2'd0, 1'b0, 1'b1, 1'b0);
        cnt = 4'd0; tick();
        chk0("t1.after", 2'd0, 1'b0, 1'b0, 1'b0);
        chk("t1.perf0", 32'(perf0), 32'd3);

        // 2: non-boundary request ignored while a 1-period flush runs
        cnt = 4'd4; flush0 = 2'd1; tick();
        chk0("t2.load", 2'd1, 1'b1, 1'b0, 1'b0);
        cnt = 4'd3; flush0 = 2'd2; tick();
        chk0("t2.nb", 2'd1, 1'b1, 1'b0, 1'b0);
        cnt = 4'd4; flush0 = 2'd0; tick();
        chk0("t2.end", 2'd0, 1'b0, 1'b1, 1'b0);
        cnt = 4'd0; tick();
        chk0("t2.idle", 2'd0, 1'b0, 1'b0, 1'b0);

        // 3: MODE 0 merge: remain=2, new request 2 -> max(1,2)=2
        cnt = 4'd4; flush0 = 2'd2; tick();
        chk0("t3.load", 2'd2, 1'b1, 1'b0, 1'b0);
        tick();
        chk0("t3.merge", 2'd2, 1'b1, 1'b0, 1'b0);

        // 5a: abort mid-flush
        cnt = 4'd0; flush0 = 2'd0; abort = 1'b1; tick();
        chk0("t5.abort", 2'd0, 1'b0, 1'b0, 1'b0);
        // 5b: abort together with a boundary request
        cnt = 4'd4; flush0 = 2'd2; tick();
        chk0("t5.abreq", 2'd0, 1'b0, 1'b0, 1'b0);
        abort = 1'b0; flush0 = 2'd0; cnt = 4'd0; tick();
        chk0("t5.idle", 2'd0, 1'b0, 1'b0, 1'b0);
        chk1("t5.idle", 2'd0, 1'b0, 1'b0, 1'b0);

        // 4: MODE 1 with clipping of the request and of the sum
        cnt = 4'd4; flush1 = 3'd7; tick();
        chk1("t4.clip", 2'd3, 1'b1, 1'b0, 1'b1);
        flush1 = 3'd3; tick();
        chk1("t4.sum", 2'd3, 1'b1, 1'b0, 1'b1);
        cnt = 4'd0; flush1 = 3'd0; tick();
        chk1("t4.hold", 2'd3, 1'b1, 1'b0, 1'b0);
        cnt = 4'd4; tick();
        chk1("t4.dec", 2'd2, 1'b1, 1'b0, 1'b0);
        flush1 = 3'd1; tick();
        chk1("t4.acc", 2'd2, 1'b1, 1'b0, 1'b0);
        chk0("t4.dut0", 2'd0, 1'b0, 1'b0, 1'b0);

        // 6: perf counter saturation and clear priority
        cnt = 4'd0; flush1 = 3'd0; perf_clr = 1'b1; tick();
        chk("t6.clr0", 32'(perf1), 32'd0);
        perf_clr = 1'b0; cnt = 4'd4; flush1 = 3'd3;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 4) chk("t6.p5", 32'(perf1), 32'd5);
        end
        chk("t6.sat", 32'(perf1), 32'd15);
        chk("t6.stall", 32'(stall1), 32'd1);
        perf_clr = 1'b1; tick();
        chk("t6.clrwin", 32'(perf1), 32'd0);
        perf_clr = 1'b0; tick();
        chk("t6.restart", 32'(perf1), 32'd1);

        // Async reset mid-flush takes effect before the next edge
        rst = 1'b1; #1;
        chk1("t6.arst", 2'd0, 1'b0, 1'b0, 1'b0);
        chk("t6.arst.perf1", 32'(perf1), 32'd0);
        chk("t6.arst.perf0", 32'(perf0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
